reorder_buffer: RTL

- Circular reorder buffer that produces the in-order retire stream consumed by stage_rt.
- Allocates entries at dispatch, marks them complete on CDB writeback, and presents the head entry as ROB_RETIRE_PACKET with rob_valid/rob_ready.
- Flushes all entries on branch_mispredict.
- Sits between dispatch/CDB and the retire stage.

---
 rtl/reorder_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retire buffer between dispatch/CDB and stage_rt.
// Entries are allocated at the tail on dispatch, marked complete by CDB writeback
// and presented at the head as rob_retire_packet until they retire.
// Optional feature macro: ROB_CDB_BYPASS_EN -- a CDB write to the head entry
// makes it retire-ready (and retire) in the same cycle.

package rob_pkg;
    typedef struct packed {
        logic [5:0]  tag;
        logic [4:0]  dest_reg;
        logic [63:0] value;
        logic        reg_valid;
        logic        mem_valid;
        logic [63:0] mem_addr;
    } ROB_RETIRE_PACKET;
endpackage

module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROB_SZ = 32,
    parameter int CNT_W  = $clog2(ROB_SZ) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dispatch_valid,
    input  logic [4:0]       dispatch_dest_reg,
    input  logic             dispatch_reg_valid,
    input  logic             dispatch_is_mem,
    output logic             dispatch_ready,
    output logic [5:0]       dispatch_tag,
    input  logic             cdb_valid,
    input  logic [5:0]       cdb_tag,
    input  logic [63:0]      cdb_value,
    input  logic [63:0]      cdb_mem_addr,
    input  logic             branch_mispredict,
    output ROB_RETIRE_PACKET rob_retire_packet,
    output logic             rob_valid,
    output logic             rob_ready,
    output logic [CNT_W-1:0] rob_count
);

    localparam int IDX_W = $clog2(ROB_SZ);

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W-1:0] cdb_idx;
    logic [CNT_W-1:0] count;

    logic [ROB_SZ-1:0] valid;
    logic [ROB_SZ-1:0] complete;
    logic [ROB_SZ-1:0] reg_valid_mem;
    logic [ROB_SZ-1:0] is_mem_mem;
    logic [4:0]        dest_mem  [ROB_SZ];
    logic [63:0]       value_mem [ROB_SZ];
    logic [63:0]       addr_mem  [ROB_SZ];

    logic cdb_in_range;
    logic cdb_hit;
    logic bypass_hit;
    logic do_dispatch;
    logic do_pop;

    // Qualify dispatch, CDB writeback and retire for this cycle.
    always_comb begin
        cdb_idx        = cdb_tag[IDX_W-1:0];
        cdb_in_range   = ({1'b0, cdb_tag} < 7'(ROB_SZ));
        cdb_hit        = cdb_valid & ~branch_mispredict & cdb_in_range
                         & valid[cdb_idx] & ~complete[cdb_idx];
`ifdef ROB_CDB_BYPASS_EN
        bypass_hit     = cdb_hit & (cdb_idx == head);
`else
        bypass_hit     = 1'b0;
`endif
        dispatch_ready = (count < CNT_W'(ROB_SZ));
        dispatch_tag   = 6'(tail);
        rob_valid      = valid[head];
        rob_ready      = valid[head] & (complete[head] | bypass_hit);
        rob_count      = count;
        do_dispatch    = dispatch_valid & dispatch_ready & ~branch_mispredict;
        do_pop         = rob_valid & rob_ready & ~branch_mispredict;
    end

    // Head entry view; value/address come straight off the CDB on a bypass hit.
    always_comb begin
        rob_retire_packet = '0;
        if (valid[head]) begin
            rob_retire_packet.tag       = 6'(head);
            rob_retire_packet.dest_reg  = dest_mem[head];
            rob_retire_packet.reg_valid = reg_valid_mem[head];
            rob_retire_packet.mem_valid = is_mem_mem[head];
            rob_retire_packet.value     = value_mem[head];
            rob_retire_packet.mem_addr  = addr_mem[head];
            if (bypass_hit) begin
                rob_retire_packet.value    = cdb_value;
                rob_retire_packet.mem_addr = cdb_mem_addr;
            end
        end
    end

    // Pointers and occupancy; a mispredict rewinds everything to empty.
    always_ff @(posedge clock) begin
        if (reset || branch_mispredict) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_dispatch) tail <= tail + 1'b1;
            if (do_pop)      head <= head + 1'b1;
            case ({do_dispatch, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry status bits; pop is applied last so a bypassed entry leaves nothing behind.
    always_ff @(posedge clock) begin
        if (reset || branch_mispredict) begin
            valid    <= '0;
            complete <= '0;
        end else begin
            if (do_dispatch) begin
                valid[tail]    <= 1'b1;
                complete[tail] <= 1'b0;
            end
            if (cdb_hit) complete[cdb_idx] <= 1'b1;
            if (do_pop) begin
                valid[head]    <= 1'b0;
                complete[head] <= 1'b0;
            end
        end
    end

    // Entry payload; dispatch and CDB never target the same entry in one cycle.
    always_ff @(posedge clock) begin
        if (do_dispatch) begin
            dest_mem[tail]      <= dispatch_dest_reg;
            reg_valid_mem[tail] <= dispatch_reg_valid;
            is_mem_mem[tail]    <= dispatch_is_mem;
            value_mem[tail]     <= '0;
            addr_mem[tail]      <= '0;
        end
        if (cdb_hit) begin
            value_mem[cdb_idx] <= cdb_value;
            addr_mem[cdb_idx]  <= cdb_mem_addr;
        end
    end

endmodule
